// File: rtl/sdram_rd_capture.sv
// Purpose: capture SDRAM read bursts cas_laten_p cycles after each accepted READ and buffer them in a show-ahead FIFO.
// Latency: first word is pushed at edge T+cas_laten_p and is visible on data_o right after that edge when the FIFO is empty.
// Backpressure: ready_i stalls the FIFO head; space_ok_o withholds READ issue until a whole burst is guaranteed to fit.
//
// Ports:
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   rd_cmd_i      : one-cycle READ issue strobe from the command state machine
//   dq_i          : SDRAM DQ read data
//   space_ok_o    : a full burst fits in the FIFO (free space minus outstanding reservations)
//   data_o/valid_o/ready_i : show-ahead head-of-FIFO handshake toward the sorting core
//   burst_done_o  : one-cycle pulse after the last word of a burst is pushed
//   err_o         : sticky flag, set when a READ strobe is rejected
//   level_o       : FIFO occupancy
module sdram_rd_capture #(
    parameter int data_width_p = 16,
    parameter int cas_laten_p  = 2,
    parameter int burst_len_p  = 4,
    parameter int fifo_depth_p = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            rd_cmd_i,
    input  logic [data_width_p-1:0]         dq_i,
    output logic                            space_ok_o,
    output logic [data_width_p-1:0]         data_o,
    output logic                            valid_o,
    input  logic                            ready_i,
    output logic                            burst_done_o,
    output logic                            err_o,
    output logic [$clog2(fifo_depth_p):0]   level_o
);

    localparam int aw_lp = $clog2(fifo_depth_p);
    localparam int dl_lp = cas_laten_p + burst_len_p;
    localparam int sw_lp = $clog2(burst_len_p + 1);
    // Credit arithmetic needs room for level + reserved + one burst (< 4*depth).
    localparam int cw_lp = aw_lp + 2;

    localparam logic [aw_lp:0]   depth_lp   = (aw_lp+1)'(fifo_depth_p);
    localparam logic [aw_lp:0]   one_lp     = (aw_lp+1)'(1);
    localparam logic [aw_lp:0]   bl_res_lp  = (aw_lp+1)'(burst_len_p);
    localparam logic [sw_lp-1:0] spc_init_lp = sw_lp'(burst_len_p - 1);
    localparam logic [cw_lp-1:0] bl_cw_lp   = cw_lp'(burst_len_p);
    localparam logic [cw_lp-1:0] depth_cw_lp = cw_lp'(fifo_depth_p);

    // dly_q[k] is set k edges after an accepted READ; the top bit doubles as burst_done.
    logic [dl_lp-1:0]        dly_q;
    logic [sw_lp-1:0]        spc_q;
    logic [aw_lp:0]          res_q;
    logic [aw_lp:0]          wr_ptr_q;
    logic [aw_lp:0]          rd_ptr_q;
    logic [data_width_p-1:0] mem_q [fifo_depth_p];
    logic [data_width_p-1:0] head_q;
    logic                    err_q;

    logic                    accept;
    logic                    push;
    logic                    pop;
    logic [aw_lp:0]          level;
    logic [aw_lp-1:0]        rd_nxt_idx;

    assign level      = wr_ptr_q - rd_ptr_q;
    assign space_ok_o = (cw_lp'(level) + cw_lp'(res_q) + bl_cw_lp) <= depth_cw_lp;
    assign accept     = rd_cmd_i && space_ok_o && (spc_q == '0);
    // Capture window for a READ accepted at edge T is edges T+CL .. T+CL+BL-1,
    // i.e. delay-line bits CL-1 .. CL+BL-2 as seen just before the edge.
    assign push       = |dly_q[cas_laten_p+burst_len_p-2 : cas_laten_p-1];
    assign valid_o    = (level != '0);
    assign pop        = valid_o && ready_i;
    assign rd_nxt_idx = rd_ptr_q[aw_lp-1:0] + 1'b1;

    assign data_o       = head_q;
    assign level_o      = level;
    assign err_o        = err_q;
    assign burst_done_o = dly_q[dl_lp-1];

    // Command tracking: delay line, spacing counter, reservations, error flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dly_q <= '0;
            spc_q <= '0;
            res_q <= '0;
            err_q <= 1'b0;
        end else begin
            dly_q <= {dly_q[dl_lp-2:0], accept};
            if (accept) begin
                spc_q <= spc_init_lp;
            end else if (spc_q != '0) begin
                spc_q <= spc_q - 1'b1;
            end
            // Reservation counts words promised to the FIFO but not yet pushed.
            res_q <= res_q + (accept ? bl_res_lp : '0) - (aw_lp+1)'(push);
            if (rd_cmd_i && !accept) begin
                err_q <= 1'b1;
            end
        end
    end

    // FIFO pointers and registered head word.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            head_q   <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            // Head follows the oldest word; with no replacement it keeps its
            // last value, so data_o is stable under stall and after draining.
            if (push && (level == '0 || (pop && level == one_lp))) begin
                head_q <= dq_i;
            end else if (pop && level > one_lp) begin
                head_q <= mem_q[rd_nxt_idx];
            end
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q[aw_lp-1:0]] <= dq_i;
        end
    end

`ifndef SYNTHESIS
    // The credit scheme must make an overflowing push impossible.
    a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
        !(push && level == depth_lp));
`endif

endmodule
